vga_sync_receiver: RTL and testbench

- Receive end of the board's VGA output: samples vga_h_sync, vga_v_sync and the 3-bit colour on the pixel clock and recovers pixel coordinates and colour.
- Used as an in-fabric loopback monitor, so the bench and on-board checkers can verify the card-grid renderer pixel by pixel.
- Locks to the incoming timing, reports the recovered (x, y, rgb) stream, and flags timing faults.

---
 rtl/vga_sync_receiver.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync lock, pixel coordinate recovery and fault counting; optional FRAME_CHECKSUM_EN adds a per-frame colour checksum
module vga_sync_receiver #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic [2:0]  vga_rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  CNT_MAX   = 10'h3FF;
    localparam logic [9:0]  H_START_C = 10'(H_START);
    localparam logic [9:0]  V_START_C = 10'(V_START);
    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] H_BEG_W   = 11'(H_START);
    localparam logic [10:0] H_END_W   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_BEG_W   = 11'(V_START);
    localparam logic [10:0] V_END_W   = 11'(V_START + V_ACTIVE);

    // Stage 1 samples and their one-cycle history
    logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [2:0] rgb_q;
    logic       hs_fall, vs_fall;

    // Counters, fault flag and state
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [9:0] v_inc;
    logic       bad_q, bad_d;
    logic       line_ok, line_bad, frame_ok, h_sat;
    state_t     state_q, state_d;
    logic       lock_loss;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Stage 2 outputs
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic [2:0] pix_rgb_q, pix_rgb_d;
    logic       frame_start_q, frame_start_d;
    logic       h_in, v_in, active;

    // Register the raw VGA inputs; history starts deasserted so no edge fires out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            rgb_q     <= 3'd0;
        end else begin
            hs_q      <= vga_h_sync;
            vs_q      <= vga_v_sync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= vga_rgb;
        end
    end

    assign hs_fall = hs_prev_q & ~hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;

    // A line is good when the count that ends at this hsync assertion equals H_TOTAL
    assign line_ok  = (({1'b0, h_cnt_q} + 11'd1) == H_TOTAL_W);
    assign line_bad = hs_fall & ~line_ok;

    // Horizontal and vertical counters; h_cnt_d/v_cnt_d are the position of the stage-1 sample
    always_comb begin
        h_cnt_d = h_cnt_q;
        if (hs_fall) begin
            h_cnt_d = 10'd0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end

        v_inc = v_cnt_q;
        if (hs_fall && (v_cnt_q != CNT_MAX)) begin
            v_inc = v_cnt_q + 10'd1;
        end
        // The line ending together with vsync still belongs to the closing frame
        v_cnt_d = vs_fall ? 10'd0 : v_inc;

        frame_ok = ({1'b0, v_inc} == V_TOTAL_W) && !bad_q && !line_bad;
        bad_d    = vs_fall ? 1'b0 : (bad_q | line_bad);
        h_sat    = (h_cnt_d == CNT_MAX);
    end

    // Lock state machine: next state and lock-loss detection
    always_comb begin
        state_d   = state_q;
        lock_loss = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (vs_fall && frame_ok) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (line_bad || (vs_fall && !frame_ok) || h_sat) begin
                    state_d   = ST_SEARCH;
                    lock_loss = 1'b1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        err_cnt_d = err_cnt_q;
        if (lock_loss && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Active-window decode and stage-2 next values; a lock loss this cycle drops pix_valid
    always_comb begin
        h_in   = ({1'b0, h_cnt_d} >= H_BEG_W) && ({1'b0, h_cnt_d} < H_END_W);
        v_in   = ({1'b0, v_cnt_d} >= V_BEG_W) && ({1'b0, v_cnt_d} < V_END_W);
        active = (state_d == ST_LOCKED) && h_in && v_in;

        pix_valid_d = active;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_rgb_d   = pix_rgb_q;
        if (active) begin
            pix_x_d   = h_cnt_d - H_START_C;
            pix_y_d   = v_cnt_d - V_START_C;
            pix_rgb_d = rgb_q;
        end

        frame_start_d = vs_fall && (state_d == ST_LOCKED);
    end

    // Counter, state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            bad_q         <= 1'b0;
            state_q       <= ST_SEARCH;
            err_cnt_q     <= 8'd0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_rgb_q     <= 3'd0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bad_q         <= bad_d;
            state_q       <= state_d;
            err_cnt_q     <= err_cnt_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_cnt     = err_cnt_q;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] sum_q, sum_d;
    logic        sum_valid_q, sum_valid_d;
    logic        primed_q, primed_d;
    logic [15:0] acc_total;

    // Accumulate displayed colour; publish and clear at each locked vsync, skipping the lock-entry frame
    always_comb begin
        acc_total   = acc_q + (pix_valid_q ? {13'd0, pix_rgb_q} : 16'd0);
        acc_d       = acc_total;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        primed_d    = primed_q;
        if (frame_start_d) begin
            acc_d    = 16'd0;
            primed_d = 1'b1;
            if (primed_q) begin
                sum_d       = acc_total;
                sum_valid_d = 1'b1;
            end
        end else if (state_d != ST_LOCKED) begin
            primed_d = 1'b0;
        end
    end

    // Checksum registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= 16'd0;
            sum_q       <= 16'd0;
            sum_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign frame_sum       = sum_q;
    assign frame_sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver on a reduced 40x20 raster
module tb_vga_sync_receiver;

    // Reduced geometry keeps each frame at 800 clocks; checks are scaled to it (24x12=288 pixels/frame)
    localparam int H_T  = 40;
    localparam int H_S  = 8;
    localparam int H_A  = 24;
    localparam int V_T  = 20;
    localparam int V_S  = 3;
    localparam int V_A  = 12;
    localparam int HS_W = 4;
    localparam int VS_W = 2;
    localparam int PIX_PER_FRAME = H_A * V_A;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_h_sync, vga_v_sync;
    logic [2:0] vga_rgb;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [2:0] pix_rgb;
    logic       frame_start, locked;
    logic [7:0] err_cnt;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0] frame_sum;
    logic        frame_sum_valid;
`endif

    vga_sync_receiver #(
        .H_TOTAL(H_T), .H_START(H_S), .H_ACTIVE(H_A),
        .V_TOTAL(V_T), .V_START(V_S), .V_ACTIVE(V_A)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .vga_rgb(vga_rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
`ifdef FRAME_CHECKSUM_EN
        , .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int edges = 0;
    always @(posedge clk) edges = edges + 1;

    // Observation counters, written only by the monitor
    int         pv_cnt = 0, fs_cnt = 0, fsv_cnt = 0, fsv_lone = 0, pat_bad = 0;
    int         lock_rise_edge = -1, lock_fall_edge = -1, first_edge = -1;
    logic       locked_prev = 1'b0;
    logic       first_seen = 1'b0, last_seen = 1'b0;
    logic [2:0] first_rgb = 3'd0, last_rgb = 3'd0, exp_rgb;
    int         sum_log[$];

    // Written only by the stimulus process
    logic pat_mode = 1'b0;
    int   frame_edge = 0, mark_edges = 0, loss_mark = 0;

    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            pv_cnt = pv_cnt + 1;
            if (pat_mode) begin
                exp_rgb = 3'((int'(pix_y) * H_A + int'(pix_x)) % 8);
                if (pix_rgb !== exp_rgb) pat_bad = pat_bad + 1;
                if (pix_x == 10'd0 && pix_y == 10'd0) begin
                    first_seen = 1'b1; first_rgb = pix_rgb; first_edge = edges;
                end
                if (pix_x == 10'(H_A - 1) && pix_y == 10'(V_A - 1)) begin
                    last_seen = 1'b1; last_rgb = pix_rgb;
                end
            end
        end
        if (frame_start === 1'b1) fs_cnt = fs_cnt + 1;
        if (locked === 1'b1 && locked_prev === 1'b0) lock_rise_edge = edges;
        if (locked === 1'b0 && locked_prev === 1'b1) lock_fall_edge = edges;
        locked_prev = locked;
`ifdef FRAME_CHECKSUM_EN
        if (frame_sum_valid === 1'b1) begin
            fsv_cnt = fsv_cnt + 1;
            sum_log.push_back(int'(frame_sum));
            if (frame_start !== 1'b1) fsv_lone = fsv_lone + 1;
        end
`endif
    end

    // mode 0: rgb=7, mode 1: rgb = pixel index mod 8, mode 2: rgb=1; long_line gets one extra clock
    task automatic drive_frame(input int nlines, input int long_line, input int mode, input int max_clk);
        int n;
        int len;
        n = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? H_T + 1 : H_T;
            for (int h = 0; h < len; h++) begin
                if (max_clk >= 0 && n >= max_clk) return;
                @(posedge clk); #1;
                vga_h_sync = (h < HS_W) ? 1'b0 : 1'b1;
                vga_v_sync = (l < VS_W) ? 1'b0 : 1'b1;
                if (mode == 0) vga_rgb = 3'd7;
                else if (mode == 2) vga_rgb = 3'd1;
                else if (l >= V_S && l < V_S + V_A && h >= H_S && h < H_S + H_A)
                    vga_rgb = 3'(((l - V_S) * H_A + (h - H_S)) % 8);
                else vga_rgb = 3'd0;
                if (l == 0 && h == 0) frame_edge = edges;
                if (mode == 1 && l == V_S && h == H_S) mark_edges = edges;
                if (long_line >= 0 && l == long_line + 1 && h == 0) loss_mark = edges;
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; vga_h_sync = 1'b1; vga_v_sync = 1'b1; vga_rgb = 3'd5;
        repeat (2) @(posedge clk); #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
        total++; if (pix_x !== 10'd0) begin bad++; $display("FAIL reset_pix_x: got %0d want 0", pix_x); end
        total++; if (pix_y !== 10'd0) begin bad++; $display("FAIL reset_pix_y: got %0d want 0", pix_y); end
        total++; if (pix_rgb !== 3'd0) begin bad++; $display("FAIL reset_pix_rgb: got %0d want 0", pix_rgb); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_nominal();
        int pv0, fs0, f2;
        pv0 = pv_cnt; fs0 = fs_cnt;
        drive_frame(V_T, -1, 0, -1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL nominal_track_after_first_vsync: got %b want 0", locked); end
        drive_frame(V_T, -1, 0, -1);
        f2 = frame_edge;
        total++; if (lock_rise_edge - f2 !== 2) begin bad++; $display("FAIL nominal_lock_delay: got %0d want 2", lock_rise_edge - f2); end
        drive_frame(V_T, -1, 0, -1);
        total++; if (pv_cnt - pv0 !== 2 * PIX_PER_FRAME) begin bad++; $display("FAIL nominal_pix_count: got %0d want %0d", pv_cnt - pv0, 2 * PIX_PER_FRAME); end
        total++; if (fs_cnt - fs0 !== 2) begin bad++; $display("FAIL nominal_frame_start: got %0d want 2", fs_cnt - fs0); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL nominal_err_cnt: got %0d want 0", err_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL nominal_locked: got %b want 1", locked); end
    endtask

    task automatic test_pixel_map();
        int pv0;
        pv0 = pv_cnt;
        pat_mode = 1'b1;
        drive_frame(V_T, -1, 1, -1);
        pat_mode = 1'b0;
        total++; if (!first_seen || first_rgb !== 3'd0) begin bad++; $display("FAIL map_first_pixel: seen=%b rgb=%0d want rgb 0", first_seen, first_rgb); end
        total++; if (!last_seen || last_rgb !== 3'd7) begin bad++; $display("FAIL map_last_pixel: seen=%b rgb=%0d want rgb 7", last_seen, last_rgb); end
        total++; if (first_edge - mark_edges !== 2) begin bad++; $display("FAIL map_latency: got %0d want 2", first_edge - mark_edges); end
        total++; if (pat_bad !== 0) begin bad++; $display("FAIL map_pattern: got %0d wrong pixels want 0", pat_bad); end
        total++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin bad++; $display("FAIL map_pix_count: got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
    endtask

    task automatic test_lock_loss();
        int pv0;
        pv0 = pv_cnt;
        drive_frame(V_T, 7, 0, -1);
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL loss_err_cnt: got %0d want 1", err_cnt); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked: got %b want 0", locked); end
        total++; if (lock_fall_edge - loss_mark !== 2) begin bad++; $display("FAIL loss_timing: got %0d want 2", lock_fall_edge - loss_mark); end
        total++; if (pv_cnt - pv0 !== 5 * H_A) begin bad++; $display("FAIL loss_pix_count: got %0d want %0d", pv_cnt - pv0, 5 * H_A); end
    endtask

    task automatic test_short_frame_track();
        int pv0, fs0;
        pv0 = pv_cnt; fs0 = fs_cnt;
        drive_frame(V_T - 1, -1, 0, -1);
        drive_frame(V_T, -1, 0, -1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_locked: got %b want 0", locked); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL short_err_cnt: got %0d want 1", err_cnt); end
        total++; if (pv_cnt - pv0 !== 0) begin bad++; $display("FAIL short_pix_count: got %0d want 0", pv_cnt - pv0); end
        total++; if (fs_cnt - fs0 !== 0) begin bad++; $display("FAIL short_frame_start: got %0d want 0", fs_cnt - fs0); end
        drive_frame(V_T, -1, 0, -1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_locked: got %b want 1", locked); end
        total++; if (fs_cnt - fs0 !== 1) begin bad++; $display("FAIL relock_frame_start: got %0d want 1", fs_cnt - fs0); end
        total++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin bad++; $display("FAIL relock_pix_count: got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
    endtask

    task automatic test_reset_midline();
        int pv0, fs0, fsv0, fb;
        drive_frame(V_T, -1, 0, 5 * H_T + 20);
        total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_pix_valid: got %b want 1", pix_valid); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %b want 1", locked); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL mid_pre_err_cnt: got %0d want 1", err_cnt); end
        #2 reset = 1'b0;
        #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_pix_valid: got %b want 0", pix_valid); end
        total++; if (pix_x !== 10'd0) begin bad++; $display("FAIL mid_pix_x: got %0d want 0", pix_x); end
        total++; if (pix_y !== 10'd0) begin bad++; $display("FAIL mid_pix_y: got %0d want 0", pix_y); end
        total++; if (pix_rgb !== 3'd0) begin bad++; $display("FAIL mid_pix_rgb: got %0d want 0", pix_rgb); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL mid_frame_start: got %b want 0", frame_start); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked: got %b want 0", locked); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
`ifdef FRAME_CHECKSUM_EN
        total++; if (frame_sum !== 16'd0) begin bad++; $display("FAIL mid_frame_sum: got %0d want 0", frame_sum); end
        total++; if (frame_sum_valid !== 1'b0) begin bad++; $display("FAIL mid_frame_sum_valid: got %b want 0", frame_sum_valid); end
`endif
        vga_h_sync = 1'b1; vga_v_sync = 1'b1; vga_rgb = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        pv0 = pv_cnt; fs0 = fs_cnt; fsv0 = fsv_cnt;
        drive_frame(V_T, -1, 0, -1);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_frame_a_locked: got %b want 0", locked); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_frame_a_err_cnt: got %0d want 0", err_cnt); end
        drive_frame(V_T, -1, 0, -1);
        fb = frame_edge;
        total++; if (lock_rise_edge - fb !== 2) begin bad++; $display("FAIL rst_relock_delay: got %0d want 2", lock_rise_edge - fb); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL rst_relock_locked: got %b want 1", locked); end
        total++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin bad++; $display("FAIL rst_pix_count: got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
        total++; if (fs_cnt - fs0 !== 1) begin bad++; $display("FAIL rst_frame_start: got %0d want 1", fs_cnt - fs0); end
`ifdef FRAME_CHECKSUM_EN
        total++; if (fsv_cnt - fsv0 !== 0) begin bad++; $display("FAIL rst_first_sum_suppressed: got %0d pulses want 0", fsv_cnt - fsv0); end
`endif
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        int fsv0, n0;
        fsv0 = fsv_cnt; n0 = sum_log.size();
        drive_frame(V_T, -1, 2, -1);
        drive_frame(V_T, -1, 2, -1);
        drive_frame(V_T, -1, 2, H_T);
        total++; if (fsv_cnt - fsv0 !== 3) begin bad++; $display("FAIL sum_pulse_count: got %0d want 3", fsv_cnt - fsv0); end
        total++; if (fsv_lone !== 0) begin bad++; $display("FAIL sum_pulse_align: got %0d unaligned want 0", fsv_lone); end
        if (sum_log.size() >= n0 + 3) begin
            total++; if (sum_log[n0] !== PIX_PER_FRAME * 7) begin bad++; $display("FAIL sum_rgb7_frame: got %0d want %0d", sum_log[n0], PIX_PER_FRAME * 7); end
            total++; if (sum_log[n0 + 1] !== PIX_PER_FRAME) begin bad++; $display("FAIL sum_rgb1_frame: got %0d want %0d", sum_log[n0 + 1], PIX_PER_FRAME); end
            total++; if (sum_log[n0 + 2] !== PIX_PER_FRAME) begin bad++; $display("FAIL sum_rgb1_frame2: got %0d want %0d", sum_log[n0 + 2], PIX_PER_FRAME); end
        end else begin
            total++; bad++; $display("FAIL sum_values: got %0d sums want 3", sum_log.size() - n0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_pixel_map();
        test_lock_loss();
        test_short_frame_track();
        test_reset_midline();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
